unidad_control_multiciclo: RTL and testbench

Main control FSM for the multicycle RV32I-subset core: lw, sw, R-type, I-type ALU, beq, jal. Sequences the shared ALU, instruction/data memory port, register file and PC through fetch, decode, execute, memory and writeback steps. Drives `aluOp` into the existing ALU decoder downstream and produces all datapath multiplexer selects and write enables.

---
 rtl/unidad_control_multiciclo_pkg.sv | 37 +++
 rtl/unidad_control_multiciclo_salidas.sv | 83 ++++++++
 rtl/unidad_control_multiciclo.sv | 55 +++++
 tb/tb_unidad_control_multiciclo.sv | 103 ++++++++++
 4 files changed

// File: rtl/unidad_control_multiciclo_pkg.sv
// unidad_control_multiciclo_pkg: shared state, opcode, aluOp and select encodings for the multicycle control unit
package unidad_control_multiciclo_pkg;
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_t;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;
  function automatic logic op_legal(input logic [6:0] op);
    return op inside {OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL};
  endfunction
endpackage

// File: rtl/unidad_control_multiciclo_salidas.sv
// control_salidas: combinational state-to-output decoder of the multicycle control FSM
module control_salidas
  import unidad_control_multiciclo_pkg::*;
(
  input  state_t     state,
  output logic [1:0] alu_op,
  output logic [1:0] src_a,
  output logic [1:0] src_b,
  output logic [1:0] result_src,
  output logic       adr_src,
  output logic       ir_write,
  output logic       reg_write,
  output logic       mem_write,
  output logic       pc_update,
  output logic       branch,
  output logic       done
);
  always_comb begin
    alu_op = ALUOP_ADD;
    src_a = SRCA_PC;
    src_b = SRCB_RS2;
    result_src = RES_ALUOUT;
    adr_src = 1'b0;
    ir_write = 1'b0;
    reg_write = 1'b0;
    mem_write = 1'b0;
    pc_update = 1'b0;
    branch = 1'b0;
    done = 1'b0;
    case (state)
      S_FETCH: begin
        src_b = SRCB_FOUR;
        result_src = RES_ALU;
        ir_write = 1'b1;
        pc_update = 1'b1;
      end
      S_DECODE: begin
        src_a = SRCA_OLDPC;
        src_b = SRCB_IMM;
      end
      S_MEMADR: begin
        src_a = SRCA_RS1;
        src_b = SRCB_IMM;
      end
      S_MEMREAD: adr_src = 1'b1;
      S_MEMWB: begin
        result_src = RES_DATA;
        reg_write = 1'b1;
        done = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src = 1'b1;
        mem_write = 1'b1;
        done = 1'b1;
      end
      S_EXECUTER: begin
        src_a = SRCA_RS1;
        alu_op = ALUOP_FUNCT;
      end
      S_EXECUTEI: begin
        src_a = SRCA_RS1;
        src_b = SRCB_IMM;
        alu_op = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        done = 1'b1;
      end
      S_BEQ: begin
        src_a = SRCA_RS1;
        alu_op = ALUOP_SUB;
        branch = 1'b1;
        done = 1'b1;
      end
      S_JAL: begin
        src_a = SRCA_OLDPC;
        src_b = SRCB_FOUR;
        pc_update = 1'b1;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/unidad_control_multiciclo.sv
// unidad_control_multiciclo: main multicycle RV32I-subset control FSM (state register, next-state, enable gating)
module unidad_control_multiciclo
  import unidad_control_multiciclo_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic       zero,
  output logic [1:0] aluOp,
  output logic [1:0] aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [1:0] resultSrc,
  output logic       adrSrc,
  output logic       irWrite,
  output logic       regWrite,
  output logic       memWrite,
  output logic       pcWrite,
  output logic       instrDone,
  output logic       illegalOp
);
  state_t state, next, shown;
  logic ir_w, reg_w, mem_w, pc_upd, br, dn, ill;
  always_ff @(posedge clk) state <= reset ? S_FETCH : next;
  always_comb begin
    next = S_FETCH;
    case (state)
      S_FETCH:    next = S_DECODE;
      S_DECODE:   next = op == OP_LW || op == OP_SW ? S_MEMADR :
                         op == OP_R   ? S_EXECUTER :
                         op == OP_I   ? S_EXECUTEI :
                         op == OP_BEQ ? S_BEQ :
                         op == OP_JAL ? S_JAL : S_FETCH;
      S_MEMADR:   next = op == OP_LW ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  next = S_MEMWB;
      S_EXECUTER: next = S_ALUWB;
      S_EXECUTEI: next = S_ALUWB;
      S_JAL:      next = S_ALUWB;
      default:    next = S_FETCH;
    endcase
  end
  // under reset the selects show FETCH values while every enable is held low
  assign shown = reset ? S_FETCH : state;
  control_salidas u_salidas (
    .state(shown), .alu_op(aluOp), .src_a(aluSrcA), .src_b(aluSrcB),
    .result_src(resultSrc), .adr_src(adrSrc), .ir_write(ir_w), .reg_write(reg_w),
    .mem_write(mem_w), .pc_update(pc_upd), .branch(br), .done(dn)
  );
  assign ill = !reset && state == S_DECODE && !op_legal(op);
  assign irWrite = !reset && ir_w;
  assign regWrite = !reset && reg_w;
  assign memWrite = !reset && mem_w;
  assign pcWrite = !reset && (pc_upd || (br && zero));
  assign instrDone = !reset && (dn || ill);
  assign illegalOp = ill;
endmodule

// File: tb/tb_unidad_control_multiciclo.sv
// tb_unidad_control_multiciclo: directed per-cycle stimulus with a queued scoreboard checked by a monitor
module tb_unidad_control_multiciclo;
  logic clk = 1'b0, reset = 1'b1, zero = 1'b0;
  logic [6:0] op = 7'd0;
  logic [1:0] aluOp, aluSrcA, aluSrcB, resultSrc;
  logic adrSrc, irWrite, regWrite, memWrite, pcWrite, instrDone, illegalOp;
  int checks = 0, passed = 0;
  logic [14:0] eq[$];
  string nq[$];
  always #5 clk = ~clk;
  unidad_control_multiciclo dut (
    .clk(clk), .reset(reset), .op(op), .zero(zero), .aluOp(aluOp), .aluSrcA(aluSrcA),
    .aluSrcB(aluSrcB), .resultSrc(resultSrc), .adrSrc(adrSrc), .irWrite(irWrite),
    .regWrite(regWrite), .memWrite(memWrite), .pcWrite(pcWrite), .instrDone(instrDone),
    .illegalOp(illegalOp)
  );
  // {aluOp, aluSrcA, aluSrcB, resultSrc, adrSrc, irWrite, regWrite, memWrite, pcWrite, instrDone, illegalOp}
  localparam logic [14:0] E_RST    = {2'b00, 2'b00, 2'b10, 2'b10, 7'b0000000};
  localparam logic [14:0] E_FETCH  = {2'b00, 2'b00, 2'b10, 2'b10, 7'b0100100};
  localparam logic [14:0] E_DEC    = {2'b00, 2'b01, 2'b01, 2'b00, 7'b0000000};
  localparam logic [14:0] E_ILL    = {2'b00, 2'b01, 2'b01, 2'b00, 7'b0000011};
  localparam logic [14:0] E_MADR   = {2'b00, 2'b10, 2'b01, 2'b00, 7'b0000000};
  localparam logic [14:0] E_MRD    = {2'b00, 2'b00, 2'b00, 2'b00, 7'b1000000};
  localparam logic [14:0] E_MWB    = {2'b00, 2'b00, 2'b00, 2'b01, 7'b0010010};
  localparam logic [14:0] E_MWR    = {2'b00, 2'b00, 2'b00, 2'b00, 7'b1001010};
  localparam logic [14:0] E_EXR    = {2'b10, 2'b10, 2'b00, 2'b00, 7'b0000000};
  localparam logic [14:0] E_EXI    = {2'b10, 2'b10, 2'b01, 2'b00, 7'b0000000};
  localparam logic [14:0] E_AWB    = {2'b00, 2'b00, 2'b00, 2'b00, 7'b0010010};
  localparam logic [14:0] E_BEQ1   = {2'b01, 2'b10, 2'b00, 2'b00, 7'b0000110};
  localparam logic [14:0] E_BEQ0   = {2'b01, 2'b10, 2'b00, 2'b00, 7'b0000010};
  localparam logic [14:0] E_JAL    = {2'b00, 2'b01, 2'b10, 2'b00, 7'b0000100};
  task automatic step(input logic [6:0] o, input logic z, input logic r, input logic [14:0] e, input string n);
    @(posedge clk);
    #1;
    op = o;
    zero = z;
    reset = r;
    eq.push_back(e);
    nq.push_back(n);
  endtask
  always @(negedge clk) begin
    if (eq.size() != 0) begin
      logic [14:0] e, a;
      string n;
      e = eq.pop_front();
      n = nq.pop_front();
      a = {aluOp, aluSrcA, aluSrcB, resultSrc, adrSrc, irWrite, regWrite, memWrite, pcWrite, instrDone, illegalOp};
      checks++;
      if (a === e) passed++;
      else $display("FAIL %s: got %b expected %b", n, a, e);
    end
  end
  initial begin
    step(7'h00, 0, 1, E_RST, "reset0");
    step(7'h00, 0, 1, E_RST, "reset1");
    step(7'b0000011, 0, 0, E_FETCH, "lw_fetch");
    step(7'b0000011, 0, 0, E_DEC, "lw_decode");
    step(7'b0000011, 0, 0, E_MADR, "lw_memadr");
    step(7'b0110011, 0, 0, E_MRD, "lw_memread");
    step(7'b1100011, 1, 0, E_MWB, "lw_memwb");
    step(7'b0100011, 0, 0, E_FETCH, "sw_fetch");
    step(7'b0100011, 0, 0, E_DEC, "sw_decode");
    step(7'b0100011, 0, 0, E_MADR, "sw_memadr");
    step(7'b0000011, 0, 0, E_MWR, "sw_memwrite");
    step(7'b0110011, 0, 0, E_FETCH, "r_fetch");
    step(7'b0110011, 0, 0, E_DEC, "r_decode");
    step(7'b0000000, 0, 0, E_EXR, "r_execute");
    step(7'b0000000, 0, 0, E_AWB, "r_aluwb");
    step(7'b0010011, 0, 0, E_FETCH, "i_fetch");
    step(7'b0010011, 0, 0, E_DEC, "i_decode");
    step(7'b0010011, 0, 0, E_EXI, "i_execute");
    step(7'b0010011, 0, 0, E_AWB, "i_aluwb");
    step(7'b1100011, 0, 0, E_FETCH, "beq1_fetch");
    step(7'b1100011, 0, 0, E_DEC, "beq1_decode");
    step(7'b1100011, 1, 0, E_BEQ1, "beq_taken");
    step(7'b1100011, 0, 0, E_FETCH, "beq0_fetch");
    step(7'b1100011, 1, 0, E_DEC, "beq0_decode");
    step(7'b1100011, 0, 0, E_BEQ0, "beq_not_taken");
    step(7'b1101111, 0, 0, E_FETCH, "jal_fetch");
    step(7'b1101111, 0, 0, E_DEC, "jal_decode");
    step(7'b1101111, 0, 0, E_JAL, "jal_pc");
    step(7'b1101111, 0, 0, E_AWB, "jal_wb");
    step(7'b0000000, 0, 0, E_FETCH, "ill_fetch");
    step(7'b0000000, 0, 0, E_ILL, "ill_decode");
    step(7'b1111111, 0, 0, E_FETCH, "ill_fetch_after");
    step(7'b1111111, 0, 0, E_ILL, "ill2_decode");
    step(7'b0000011, 0, 0, E_FETCH, "lwr_fetch");
    step(7'b0000011, 0, 0, E_DEC, "lwr_decode");
    step(7'b0000011, 0, 0, E_MADR, "lwr_memadr");
    step(7'b0000011, 1, 1, E_RST, "lwr_reset_memread");
    step(7'b0000011, 0, 0, E_FETCH, "lwr_refetch");
    step(7'b0000011, 0, 0, E_DEC, "lwr_redecode");
    step(7'b0100011, 0, 0, E_MADR, "lwr_memadr2");
    step(7'b0100011, 0, 0, E_MWR, "lwr_as_sw");
    step(7'b0100011, 0, 0, E_FETCH, "final_fetch");
    repeat (2) @(negedge clk);
    checks++;
    if (eq.size() == 0) passed++;
    else $display("FAIL drain: %0d left expected 0", eq.size());
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
